// File: rtl/pio.sv
// pio: four-state-machine programmable I/O block (RP2040 PIO subset).
// All four SMs share a 32x16 instruction memory, each has a 4-deep TX and RX
// FIFO, and together they drive a 32-bit GPIO bank.
//
// Ports:
//   clk       single clock
//   reset     asynchronous, active-low reset
//   action    host command (1 INSTR, 2 PEND, 3 PULL, 4 PUSH, 5 GRPS, 6 EN,
//             7 DIV, 9 IMM; everything else is ignored)
//   index     instruction-memory address for INSTR
//   mindex    target SM for per-SM actions
//   din       command data
//   dout      word returned by PULL (0 when the RX FIFO was empty)
//   gpio_in   pin input levels (WAIT source)
//   gpio_out  pin output values
//   gpio_dir  pin directions, 1 = output
//   tx_full   per-SM TX FIFO full (registered)
//   rx_empty  per-SM RX FIFO empty (registered)
//
// Build option: PIO_FRAC_DIV_EN -- when defined the divider honours the 8-bit
// fraction; otherwise the divider is int<<8 with int 0 read as 1.
module pio #(
  parameter int NUM_SM     = 4,
  parameter int FIFO_DEPTH = 4   // must be a power of two
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [5:0]        action,
  input  logic [4:0]        index,
  input  logic [1:0]        mindex,
  input  logic [31:0]       din,
  output logic [31:0]       dout,
  input  logic [31:0]       gpio_in,
  output logic [31:0]       gpio_out,
  output logic [31:0]       gpio_dir,
  output logic [NUM_SM-1:0] tx_full,
  output logic [NUM_SM-1:0] rx_empty
);
  localparam int PW = $clog2(FIFO_DEPTH);
  localparam int CW = PW + 1;
  localparam logic [CW-1:0] FULL_CNT = CW'(FIFO_DEPTH);

  localparam logic [5:0] ACT_INSTR = 6'd1, ACT_PEND = 6'd2, ACT_PULL = 6'd3,
                         ACT_PUSH  = 6'd4, ACT_GRPS = 6'd5, ACT_EN   = 6'd6,
                         ACT_DIV   = 6'd7, ACT_IMM  = 6'd9;

  logic [15:0]       imem     [32];
  logic [4:0]        pc       [NUM_SM];
  logic [4:0]        dly      [NUM_SM];
  logic [4:0]        wrap_top [NUM_SM];
  logic [4:0]        wrap_bot [NUM_SM];
  logic [4:0]        set_base [NUM_SM];
  logic [2:0]        set_cnt  [NUM_SM];
  logic [31:0]       x        [NUM_SM];
  logic [31:0]       y        [NUM_SM];
  logic [31:0]       isr      [NUM_SM];
  logic [31:0]       osr      [NUM_SM];
  logic [23:0]       acc      [NUM_SM];
  logic [23:0]       div      [NUM_SM];
  logic [15:0]       imm_ins  [NUM_SM];
  logic [NUM_SM-1:0] en, imm_v;

  logic [31:0]       tx_mem [NUM_SM][FIFO_DEPTH];
  logic [31:0]       rx_mem [NUM_SM][FIFO_DEPTH];
  logic [PW-1:0]     tx_wp [NUM_SM], tx_rp [NUM_SM], rx_wp [NUM_SM], rx_rp [NUM_SM];
  logic [CW-1:0]     tx_cnt [NUM_SM], rx_cnt [NUM_SM];

  logic [4:0]        pc_n   [NUM_SM];
  logic [4:0]        dly_n  [NUM_SM];
  logic [31:0]       x_n    [NUM_SM];
  logic [31:0]       y_n    [NUM_SM];
  logic [31:0]       isr_n  [NUM_SM];
  logic [31:0]       osr_n  [NUM_SM];
  logic [23:0]       acc_n  [NUM_SM];
  logic [15:0]       ins    [NUM_SM];
  logic [CW-1:0]     tx_cnt_n [NUM_SM], rx_cnt_n [NUM_SM];
  logic [NUM_SM-1:0] imm_done, pin_wr, dir_wr, tx_pop, rx_push;
  logic [NUM_SM-1:0] host_push, host_pop, host_pull;
  logic [31:0]       gout_n, gdir_n;

  logic [23:0] de, asum;
  logic        stall, jmp, src_ok;
  logic [31:0] src;
  logic [15:0] op;
  logic [4:0]  p;
  logic [7:0]  sd;

  always_comb begin
    de = 24'h000100; asum = '0; stall = 1'b0; jmp = 1'b0;
    src = '0; src_ok = 1'b0; op = '0; p = '0; sd = '0;

    for (int i = 0; i < NUM_SM; i++)
      host_pull[i] = (action == ACT_PULL) && (int'(mindex) == i);

    for (int i = 0; i < NUM_SM; i++) begin
      pc_n[i] = pc[i]; dly_n[i] = dly[i]; acc_n[i] = acc[i];
      x_n[i] = x[i]; y_n[i] = y[i]; isr_n[i] = isr[i]; osr_n[i] = osr[i];
      imm_done[i] = 1'b0; pin_wr[i] = 1'b0; dir_wr[i] = 1'b0;
      tx_pop[i] = 1'b0; rx_push[i] = 1'b0;
      stall = 1'b0; jmp = 1'b0; src = '0; src_ok = 1'b0;
      // A pending host IMM replaces the fetch but never moves the PC.
      op = imm_v[i] ? imm_ins[i] : imem[pc[i]];
      ins[i] = op;
`ifdef PIO_FRAC_DIV_EN
      de = (div[i] < 24'h000100) ? 24'h000100 : div[i];
`else
      de = (div[i][23:8] == 16'h0) ? 24'h000100 : {div[i][23:8], 8'h00};
`endif
      asum = acc[i] + 24'h000100;
      if (en[i]) begin
        if (asum >= de) begin
          acc_n[i] = asum - de;
          if (dly[i] != 5'd0) begin
            dly_n[i] = dly[i] - 5'd1;
          end else begin
            case (op[15:13])
              3'b000: case (op[7:5])
                3'd0: jmp = 1'b1;
                3'd1: jmp = (x[i] == 32'd0);
                3'd2: begin jmp = (x[i] != 32'd0); x_n[i] = x[i] - 32'd1; end
                3'd3: jmp = (y[i] == 32'd0);
                3'd4: begin jmp = (y[i] != 32'd0); y_n[i] = y[i] - 32'd1; end
                3'd5: jmp = (x[i] != y[i]);
                default: jmp = 1'b0;
              endcase
              3'b001: stall = (gpio_in[op[4:0]] != op[7]);
              3'b100: begin
                if (op[7]) begin
                  if (tx_cnt[i] == '0) stall = 1'b1;
                  else begin tx_pop[i] = 1'b1; osr_n[i] = tx_mem[i][tx_rp[i]]; end
                end else begin
                  // A host PULL on the same edge frees the slot we need.
                  if (rx_cnt[i] == FULL_CNT && !host_pull[i]) stall = 1'b1;
                  else begin rx_push[i] = 1'b1; isr_n[i] = '0; end
                end
              end
              3'b101: begin
                src_ok = 1'b1;
                case (op[2:0])
                  3'd1: src = x[i];
                  3'd2: src = y[i];
                  3'd3: src = '0;
                  3'd6: src = isr[i];
                  3'd7: src = osr[i];
                  default: src_ok = 1'b0;
                endcase
                if (src_ok) begin
                  case (op[7:5])
                    3'd1: x_n[i] = src;
                    3'd2: y_n[i] = src;
                    3'd6: isr_n[i] = src;
                    3'd7: osr_n[i] = src;
                    default: ;
                  endcase
                end
              end
              3'b111: case (op[7:5])
                3'd0: pin_wr[i] = 1'b1;
                3'd1: x_n[i] = {27'd0, op[4:0]};
                3'd2: y_n[i] = {27'd0, op[4:0]};
                3'd4: dir_wr[i] = 1'b1;
                default: ;
              endcase
              default: ;
            endcase
            // Stalls hold the PC and skip the delay load.
            if (!stall) begin
              dly_n[i] = op[12:8];
              if (imm_v[i])                imm_done[i] = 1'b1;
              else if (jmp)                pc_n[i] = op[4:0];
              else if (pc[i] == wrap_top[i]) pc_n[i] = wrap_bot[i];
              else                         pc_n[i] = pc[i] + 5'd1;
            end
          end
        end else begin
          acc_n[i] = asum;
        end
      end
    end

    for (int i = 0; i < NUM_SM; i++) begin
      host_push[i] = (action == ACT_PUSH) && (int'(mindex) == i) &&
                     ((tx_cnt[i] != FULL_CNT) || tx_pop[i]);
      host_pop[i]  = host_pull[i] && (rx_cnt[i] != '0);
      tx_cnt_n[i]  = tx_cnt[i] + CW'(host_push[i]) - CW'(tx_pop[i]);
      rx_cnt_n[i]  = rx_cnt[i] + CW'(rx_push[i]) - CW'(host_pop[i]);
    end

    // Ascending SM order: the highest-numbered writer of a pin wins.
    gout_n = gpio_out;
    gdir_n = gpio_dir;
    for (int i = 0; i < NUM_SM; i++) begin
      for (int k = 0; k < 7; k++) begin
        if (3'(k) < set_cnt[i]) begin
          p  = set_base[i] + 5'(k);
          sd = {3'b000, ins[i][4:0]};
          if (pin_wr[i]) gout_n[p] = sd[3'(k)];
          if (dir_wr[i]) gdir_n[p] = sd[3'(k)];
        end
      end
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int j = 0; j < 32; j++) imem[j] <= '0;
      for (int i = 0; i < NUM_SM; i++) begin
        pc[i] <= '0; dly[i] <= '0; wrap_top[i] <= '0; wrap_bot[i] <= '0;
        set_base[i] <= '0; set_cnt[i] <= '0; x[i] <= '0; y[i] <= '0;
        isr[i] <= '0; osr[i] <= '0; acc[i] <= '0; div[i] <= '0; imm_ins[i] <= '0;
        tx_wp[i] <= '0; tx_rp[i] <= '0; rx_wp[i] <= '0; rx_rp[i] <= '0;
        tx_cnt[i] <= '0; rx_cnt[i] <= '0;
        for (int j = 0; j < FIFO_DEPTH; j++) begin
          tx_mem[i][j] <= '0;
          rx_mem[i][j] <= '0;
        end
      end
      en <= '0; imm_v <= '0; dout <= '0;
      gpio_out <= '0; gpio_dir <= '0; tx_full <= '0; rx_empty <= '1;
    end else begin
      for (int i = 0; i < NUM_SM; i++) begin
        pc[i] <= pc_n[i]; dly[i] <= dly_n[i]; acc[i] <= acc_n[i];
        x[i] <= x_n[i]; y[i] <= y_n[i]; isr[i] <= isr_n[i]; osr[i] <= osr_n[i];
        if (imm_done[i]) imm_v[i] <= 1'b0;
        if (host_push[i]) begin
          tx_mem[i][tx_wp[i]] <= din;
          tx_wp[i] <= tx_wp[i] + 1'b1;
        end
        if (tx_pop[i]) tx_rp[i] <= tx_rp[i] + 1'b1;
        if (rx_push[i]) begin
          rx_mem[i][rx_wp[i]] <= isr[i];
          rx_wp[i] <= rx_wp[i] + 1'b1;
        end
        if (host_pop[i]) rx_rp[i] <= rx_rp[i] + 1'b1;
        tx_cnt[i]   <= tx_cnt_n[i];
        rx_cnt[i]   <= rx_cnt_n[i];
        tx_full[i]  <= (tx_cnt_n[i] == FULL_CNT);
        rx_empty[i] <= (rx_cnt_n[i] == '0);
      end
      gpio_out <= gout_n;
      gpio_dir <= gdir_n;
      case (action)
        ACT_INSTR: imem[index] <= din[15:0];
        ACT_PEND: begin
          wrap_top[mindex] <= din[16:12];
          wrap_bot[mindex] <= din[11:7];
        end
        ACT_PULL: dout <= (rx_cnt[mindex] != '0) ? rx_mem[mindex][rx_rp[mindex]] : 32'd0;
        ACT_GRPS: begin
          set_base[mindex] <= din[9:5];
          set_cnt[mindex]  <= din[28:26];
        end
        ACT_EN:  en <= din[NUM_SM-1:0];
        ACT_DIV: div[mindex] <= din[23:0];
        ACT_IMM: begin
          imm_v[mindex]   <= 1'b1;
          imm_ins[mindex] <= din[15:0];
        end
        default: ;
      endcase
    end
  end
endmodule

// File: tb/tb_pio.sv
// Scoreboarded bench for pio: drivers push expected GPIO transitions and
// PULL data into queues; a monitor pops and compares as the DUT presents them.
module tb_pio;
  logic        clk = 1'b0;
  logic        reset;
  logic [5:0]  action;
  logic [4:0]  index;
  logic [1:0]  mindex;
  logic [31:0] din, dout, gpio_in, gpio_out, gpio_dir;
  logic [3:0]  tx_full, rx_empty;

  pio dut (
    .clk(clk), .reset(reset), .action(action), .index(index), .mindex(mindex),
    .din(din), .dout(dout), .gpio_in(gpio_in), .gpio_out(gpio_out),
    .gpio_dir(gpio_dir), .tx_full(tx_full), .rx_empty(rx_empty)
  );

  always #5 clk = ~clk;

  typedef struct { logic [63:0] val; int gap; } gexp_t;  // gap 0 = don't care
  gexp_t       gq[$];
  logic [31:0] dq[$];
  int checks = 0, failures = 0, cyc = 0;
  logic pull_seen = 1'b0;

  always @(posedge clk) begin
    cyc       <= cyc + 1;
    pull_seen <= (action == 6'd3);
  end

  // Monitor: compares every GPIO change and every PULL result.
  initial begin
    logic [63:0] prev_g, g;
    int          last_chg;
    gexp_t       e;
    logic [31:0] d;
    prev_g = '0; last_chg = 0;
    forever begin
      @(negedge clk);
      g = {gpio_dir, gpio_out};
      if (g !== prev_g) begin
        checks++;
        if (gq.size() == 0) begin
          failures++;
          $display("FAIL gpio_unexpected got=%h", g);
        end else begin
          e = gq.pop_front();
          if (g !== e.val || (e.gap != 0 && (cyc - last_chg) != e.gap)) begin
            failures++;
            $display("FAIL gpio_change got=%h gap=%0d exp=%h gap=%0d",
                     g, cyc - last_chg, e.val, e.gap);
          end
        end
        prev_g = g; last_chg = cyc;
      end
      if (pull_seen) begin
        checks++;
        if (dq.size() == 0) begin
          failures++;
          $display("FAIL pull_unexpected dout=%h", dout);
        end else begin
          d = dq.pop_front();
          if (dout !== d) begin
            failures++;
            $display("FAIL pull_data got=%h exp=%h", dout, d);
          end
        end
      end
    end
  end

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%h exp=%h", name, got, exp);
    end
  endtask

  task automatic cmd(input logic [5:0] a, input logic [1:0] m, input logic [31:0] d,
                     input logic [4:0] idx = 5'd0);
    @(negedge clk);
    action = a; mindex = m; din = d; index = idx;
    @(posedge clk);
    #1 action = 6'd0;
  endtask

  task automatic exp_g(input logic [31:0] dir, input logic [31:0] out, input int gap);
    gq.push_back('{{dir, out}, gap});
  endtask

  task automatic wait_gq(input string name, input int max_cyc);
    for (int n = 0; n < max_cyc && gq.size() != 0; n++) @(negedge clk);
    checks++;
    if (gq.size() != 0) begin
      failures++;
      $display("FAIL %s timeout pending=%0d exp=0", name, gq.size());
      gq.delete();
    end
  endtask

  task automatic pulse_reset();
    @(negedge clk); reset = 1'b0;
    @(negedge clk); reset = 1'b1;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog expired");
    $fatal(1);
  end

  initial begin
    logic [31:0] words [5];
    words = '{32'h12345678, 32'hDEADBEEF, 32'h00000001, 32'hA5A55A5A, 32'h0BADF00D};
    reset = 1'b0; action = '0; index = '0; mindex = '0; din = '0; gpio_in = '0;
    #12;
    chk("rst_gpio_out", gpio_out, 32'h0);
    chk("rst_gpio_dir", gpio_dir, 32'h0);
    chk("rst_dout", dout, 32'h0);
    chk("rst_tx_full", {28'h0, tx_full}, 32'h0);
    chk("rst_rx_empty", {28'h0, rx_empty}, 32'hF);
    @(negedge clk); reset = 1'b1;

    // Square wave: SET pins,1 / SET pins,0 looping, div 2.5 (or 2 without frac).
    cmd(6'd1, 2'd0, 32'hE001, 5'd0);
    cmd(6'd1, 2'd0, 32'hE000, 5'd1);
    cmd(6'd2, 2'd0, 32'h00001000);
    cmd(6'd7, 2'd0, 32'h00000280);
    cmd(6'd5, 2'd0, 32'h04000000);
    for (int t = 0; t < 7; t++) begin
`ifdef PIO_FRAC_DIV_EN
      exp_g(32'h0, {31'h0, ~t[0]}, (t == 0) ? 0 : (t[0] ? 2 : 3));
`else
      exp_g(32'h0, {31'h0, ~t[0]}, (t == 0) ? 0 : 2);
`endif
    end
    cmd(6'd6, 2'd0, 32'h1);
    wait_gq("square_wave", 200);

    // Reset mid-run: pin is high here, must drop at once.
    exp_g(32'h0, 32'h0, 0);
    #2 reset = 1'b0;
    #1;
    chk("midrst_gpio_out", gpio_out, 32'h0);
    chk("midrst_rx_empty", {28'h0, rx_empty}, 32'hF);
    chk("midrst_tx_full", {28'h0, tx_full}, 32'h0);
    @(negedge clk); @(negedge clk); reset = 1'b1;
    repeat (20) @(negedge clk);
    chk("midrst_sm_disabled", gpio_out, 32'h0);
    wait_gq("midrst_seen", 5);

    // FIFO loop: PULL; MOV isr,osr; PUSH.
    cmd(6'd1, 2'd0, 32'h80A0, 5'd0);
    cmd(6'd1, 2'd0, 32'hA0C7, 5'd1);
    cmd(6'd1, 2'd0, 32'h8020, 5'd2);
    cmd(6'd2, 2'd0, 32'h00002000);
    cmd(6'd6, 2'd0, 32'h1);
    for (int w = 0; w < 4; w++) cmd(6'd4, 2'd0, words[w]);
    repeat (30) @(negedge clk);
    chk("loop_rx_nonempty", {31'h0, rx_empty[0]}, 32'h0);
    chk("loop_tx_drained", {31'h0, tx_full[0]}, 32'h0);
    for (int w = 0; w < 4; w++) begin
      dq.push_back(words[w]);
      cmd(6'd3, 2'd0, 32'h0);
    end
    @(negedge clk);
    chk("loop_rx_empty_after4", {31'h0, rx_empty[0]}, 32'h1);
    dq.push_back(32'h0);
    cmd(6'd3, 2'd0, 32'h0);

    // TX full: SM0 frozen, 5 pushes, 5th dropped.
    cmd(6'd6, 2'd0, 32'h0);
    for (int w = 0; w < 5; w++) begin
      cmd(6'd4, 2'd0, words[w] ^ 32'hFFFF0000);
      if (w == 2) chk("txfull_after3", {31'h0, tx_full[0]}, 32'h0);
      if (w == 3) chk("txfull_after4", {31'h0, tx_full[0]}, 32'h1);
      if (w == 4) chk("txfull_after5", {31'h0, tx_full[0]}, 32'h1);
    end
    cmd(6'd6, 2'd0, 32'h1);
    repeat (30) @(negedge clk);
    chk("txfull_drained", {31'h0, tx_full[0]}, 32'h0);
    for (int w = 0; w < 4; w++) begin
      dq.push_back(words[w] ^ 32'hFFFF0000);
      cmd(6'd3, 2'd0, 32'h0);
    end
    repeat (10) @(negedge clk);
    chk("txfull_fifth_dropped", {31'h0, rx_empty[0]}, 32'h1);

    // Delay/JMP: SET X,3; SET pins,1 [2]; JMP X-- 1; SET pins,0; WAIT pin0==1;
    // SET pins,1; JMP 6. Each loop pass is SET + 2 delay + JMP = 4 clk,
    // four passes give 16 clk high.
    pulse_reset();
    cmd(6'd1, 2'd0, 32'hE023, 5'd0);
    cmd(6'd1, 2'd0, 32'hE201, 5'd1);
    cmd(6'd1, 2'd0, 32'h0041, 5'd2);
    cmd(6'd1, 2'd0, 32'hE000, 5'd3);
    cmd(6'd1, 2'd0, 32'h2080, 5'd4);
    cmd(6'd1, 2'd0, 32'hE001, 5'd5);
    cmd(6'd1, 2'd0, 32'h0006, 5'd6);
    cmd(6'd2, 2'd0, 32'h0001F000);
    cmd(6'd7, 2'd0, 32'h00000100);
    cmd(6'd5, 2'd0, 32'h04000000);
    exp_g(32'h0, 32'h1, 0);
    exp_g(32'h0, 32'h0, 16);
    cmd(6'd6, 2'd0, 32'h1);
    wait_gq("delay_jmp", 100);
    repeat (10) @(negedge clk);

    // IMM on an SM stalled at WAIT: pindir 5 set, PC stays on the WAIT.
    cmd(6'd5, 2'd0, 32'h040000A0);
    exp_g(32'h20, 32'h0, 0);
    cmd(6'd9, 2'd0, 32'hE081);
    wait_gq("imm_pindir", 20);
    repeat (5) @(negedge clk);
    exp_g(32'h20, 32'h20, 0);
    @(negedge clk); gpio_in = 32'h1;
    wait_gq("imm_pc_kept", 20);
    repeat (5) @(negedge clk);

    checks++;
    if (dq.size() != 0 || gq.size() != 0) begin
      failures++;
      $display("FAIL leftover_expect dq=%0d gq=%0d exp=0", dq.size(), gq.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
